ex_muldiv_seq: RTL and testbench

Sequencer for RV32M multiply/divide operations in the EX stage. The main ALU is single-cycle. This block runs an iterative shift-add multiplier and a restoring divider over 32 cycles. It holds the pipeline through STALL_MD while it works, then presents one result for one cycle. It sits beside the ALU and takes the already-forwarded operands (the forwardA/forwardB mux outputs) plus FUNCT3_EX. The EX result mux selects RESULT_MD when DONE_MD is high.

---
 rtl/ex_muldiv_seq.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer for the EX stage: 32-step shift-add multiplier and
// restoring divider. It stalls the pipeline while busy and presents a one-cycle result.
module ex_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        START_MD,
  input  logic [2:0]  FUNCT3_EX,
  input  logic [31:0] OP_A,
  input  logic [31:0] OP_B,
  input  logic        FLUSH_MD,
  output logic        STALL_MD,
  output logic        DONE_MD,
  output logic [31:0] RESULT_MD,
  output logic        BUSY_MD
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] result_q, result_d;

  logic        a_signed, b_signed;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic        div_by_zero, div_ovf;
  logic [32:0] add_sum;
  logic [32:0] shifted_rem;
  logic        no_borrow;
  logic [31:0] rem_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] fix_result;

  // Operand conditioning on the incoming instruction: signedness, magnitudes, fast-path detection.
  always_comb begin
    a_signed    = (FUNCT3_EX == 3'b001) || (FUNCT3_EX == 3'b010) ||
                  (FUNCT3_EX == 3'b100) || (FUNCT3_EX == 3'b110);
    b_signed    = (FUNCT3_EX == 3'b001) || (FUNCT3_EX == 3'b100) ||
                  (FUNCT3_EX == 3'b110);
    sign_a      = a_signed & OP_A[31];
    sign_b      = b_signed & OP_B[31];
    mag_a       = sign_a ? (~OP_A + 32'd1) : OP_A;
    mag_b       = sign_b ? (~OP_B + 32'd1) : OP_B;
    div_by_zero = FUNCT3_EX[2] && (OP_B == 32'd0);
    div_ovf     = FUNCT3_EX[2] && !FUNCT3_EX[0] &&
                  (OP_A == 32'h8000_0000) && (OP_B == 32'hFFFF_FFFF);
  end

  // Iteration datapath and final sign correction / word selection.
  always_comb begin
    add_sum     = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
    shifted_rem = acc_q[63:31];
    no_borrow   = (shifted_rem >= {1'b0, opb_q});
    rem_diff    = shifted_rem[31:0] - opb_q;
    prod_fix    = neg_q ? (~acc_q + 64'd1) : acc_q;
    quot_fix    = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix     = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    case (funct3_q)
      3'b000:                 fix_result = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[63:32];
      3'b100, 3'b101:         fix_result = quot_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (START_MD && !FLUSH_MD) begin
          funct3_d = FUNCT3_EX;
          cnt_d    = 5'd0;
          if (div_by_zero) begin
            result_d = FUNCT3_EX[1] ? OP_A : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = FUNCT3_EX[1] ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            acc_d     = {32'd0, mag_a};
            opb_d     = mag_b;
            neg_d     = sign_a ^ sign_b;
            rem_neg_d = sign_a;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        // Divide keeps remainder in the high word and grows the quotient into the low word.
        if (funct3_q[2]) begin
          if (no_borrow) acc_d = {rem_diff, acc_q[30:0], 1'b1};
          else           acc_d = {acc_q[62:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {add_sum, acc_q[31:1]};
          else          acc_d = {1'b0, acc_q[63:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        result_d = fix_result;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A squashed instruction never updates the result.
    if (FLUSH_MD) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      funct3_q  <= 3'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
    end
  end

  assign STALL_MD  = ((state_q == IDLE) && START_MD && !FLUSH_MD && !reset) ||
                     (state_q == CALC) || (state_q == FIX);
  assign DONE_MD   = (state_q == DONE);
  assign BUSY_MD   = (state_q != IDLE);
  assign RESULT_MD = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: directed M-extension ops, flush and mid-op reset,
// with a decoupled monitor checking every DONE_MD result and its arrival cycle.
module tb_ex_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        START_MD;
  logic [2:0]  FUNCT3_EX;
  logic [31:0] OP_A;
  logic [31:0] OP_B;
  logic        FLUSH_MD;
  logic        STALL_MD;
  logic        DONE_MD;
  logic [31:0] RESULT_MD;
  logic        BUSY_MD;

  typedef struct {
    logic [31:0] result;
    int          cycle;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ex_muldiv_seq dut (
    .clk       (clk),
    .reset     (reset),
    .START_MD  (START_MD),
    .FUNCT3_EX (FUNCT3_EX),
    .OP_A      (OP_A),
    .OP_B      (OP_B),
    .FLUSH_MD  (FLUSH_MD),
    .STALL_MD  (STALL_MD),
    .DONE_MD   (DONE_MD),
    .RESULT_MD (RESULT_MD),
    .BUSY_MD   (BUSY_MD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DONE_MD pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (DONE_MD) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL spurious_done: got result %0h with no op outstanding (cycle %0d)",
                 RESULT_MD, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", RESULT_MD, e.result);
        checkOutput("done_cycle", cyc, e.cycle);
      end
    end
  end

  // Issues one op at a negedge, holds START_MD through DONE, returns at the next negedge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int lat, input string name);
    int stall_cnt;
    bit seen;
    FUNCT3_EX = f3;
    OP_A      = a;
    OP_B      = b;
    START_MD  = 1'b1;
    sb.push_back('{exp_res, cyc + lat});
    #1;
    stall_cnt = STALL_MD ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (DONE_MD) begin
        seen = 1'b1;
        checkOutput({name, "_stall_at_done"}, STALL_MD, 0);
      end else if (STALL_MD) begin
        stall_cnt++;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no DONE_MD expected one within 60 cycles", name);
    end
    checkOutput({name, "_stall_cycles"}, stall_cnt, lat);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    START_MD  = 1'b0;
    FLUSH_MD  = 1'b0;
    FUNCT3_EX = 3'b000;
    OP_A      = 32'd0;
    OP_B      = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_stall", STALL_MD, 0);
    checkOutput("rst_done", DONE_MD, 0);
    checkOutput("rst_busy", BUSY_MD, 0);
    checkOutput("rst_result", RESULT_MD, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_busy", BUSY_MD, 0);

    applyStimulus(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
    applyStimulus(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    applyStimulus(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");
    applyStimulus(3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, "mulhsu");
    applyStimulus(3'b011, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 34, "mulhu_pow");
    applyStimulus(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, "div");
    applyStimulus(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, "rem");
    applyStimulus(3'b101, 32'd100,        32'd7,         32'd14,        34, "divu");
    applyStimulus(3'b111, 32'd100,        32'd7,         32'd2,         34, "remu");
    applyStimulus(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu_zero");
    applyStimulus(3'b111, 32'd5,          32'd0,         32'd5,         1,  "remu_zero");
    applyStimulus(3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1,  "rem_zero");
    applyStimulus(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    applyStimulus(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");
    applyStimulus(3'b000, 32'd6,          32'd7,         32'd42,        34, "mul_after_fast");

    // Flush in CALC at counter 10; the squashed op pushes no expectation.
    FUNCT3_EX = 3'b000;
    OP_A      = 32'd9;
    OP_B      = 32'd9;
    START_MD  = 1'b1;
    repeat (11) @(negedge clk);
    checkOutput("flush_pre_busy", BUSY_MD, 1);
    FLUSH_MD = 1'b1;
    @(negedge clk);
    checkOutput("flush_busy", BUSY_MD, 0);
    checkOutput("flush_stall", STALL_MD, 0);
    checkOutput("flush_result_held", RESULT_MD, 32'd42);
    @(negedge clk);
    checkOutput("flush_start_busy", BUSY_MD, 0);
    FLUSH_MD = 1'b0;
    START_MD = 1'b0;
    @(negedge clk);
    applyStimulus(3'b000, 32'd3, 32'd4, 32'd12, 34, "mul_after_flush");

    // Asynchronous reset landing in FIX.
    FUNCT3_EX = 3'b101;
    OP_A      = 32'd1000;
    OP_B      = 32'd3;
    START_MD  = 1'b1;
    repeat (33) @(negedge clk);
    checkOutput("fix_stall", STALL_MD, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_stall", STALL_MD, 0);
    checkOutput("arst_done", DONE_MD, 0);
    checkOutput("arst_busy", BUSY_MD, 0);
    checkOutput("arst_result", RESULT_MD, 0);
    START_MD = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_done", DONE_MD, 0);

    // Back-to-back with START_MD never dropping across DONE.
    applyStimulus(3'b101, 32'd1000, 32'd3, 32'd333, 34, "divu_b2b");
    applyStimulus(3'b111, 32'd1000, 32'd3, 32'd1,   34, "remu_b2b");
    START_MD = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("end_busy", BUSY_MD, 0);
    checkOutput("pending_ops", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
